llsc_monitor: RTL and testbench

Parametrised load-linked/store-conditional reservation monitor. It succeeds the single LLbit register and tracks one link per hardware context. Each link holds a reservation address, supports snoop invalidation, per-context flush and an optional watchdog timeout. It sits beside the MEM/WB boundary and answers SC pass/fail queries from the MEM stage.

---
 rtl/llsc_pkg.sv | 24 ++
 rtl/llsc_link_slot.sv | 115 +++++++++++
 rtl/llsc_monitor.sv | 93 +++++++++
 tb/tb_llsc_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llsc_pkg.sv
// llsc_pkg
// Shared definitions for the LL/SC reservation monitor: reset and write
// enable polarities, the context-index width helper and the granule-aligned
// address compare used by every link slot.
package llsc_pkg;

  // Reset is asserted when rst carries this value (active-low block).
  localparam logic RstEnable   = 1'b0;
  localparam logic WriteEnable = 1'b1;

  // Width of a context index; a single-context monitor still gets a 1-bit port.
  function automatic int ctx_w(input int num_ctx);
    return (num_ctx > 1) ? $clog2(num_ctx) : 1;
  endfunction

  // Two addresses fall in the same reservation granule when they agree on
  // every bit above the granule offset. Callers zero-extend to 64 bits.
  function automatic logic gran_match(input logic [63:0] a,
                                      input logic [63:0] b,
                                      input int          gran_log2);
    return ((a ^ b) >> gran_log2) == 64'd0;
  endfunction

endpackage

// File: rtl/llsc_link_slot.sv
// llsc_link_slot
// One hardware context's reservation: valid bit, granule tag and watchdog
// counter, with the next-state priority flush > SC > LL > snoop > timeout.
// Ports:
//   clk, rst        clock, async active-low reset
//   flush           clear this link
//   sc_hit          an SC for this context is in MEM this cycle
//   ll_hit          an LL for this context retires this cycle
//   ll_addr         LL address
//   sc_addr         SC address (broadcast to all slots)
//   st_snoop        committed store visible
//   st_addr         snooped store address
//   link_valid      registered valid bit
//   reg_match       registered link covers sc_addr
//   byp_match       link after this cycle's flush/LL/snoop/timeout covers sc_addr
//   tmo_pulse       registered one-cycle expiry pulse
module llsc_link_slot
  import llsc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int GRAN_LOG2 = 2,
  parameter int TMO_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              sc_hit,
  input  logic              ll_hit,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic              st_snoop,
  input  logic [ADDR_W-1:0] st_addr,
  output logic              link_valid,
  output logic              reg_match,
  output logic              byp_match,
  output logic              tmo_pulse
);

  localparam int TAG_W = ADDR_W - GRAN_LOG2;
  // A zero-width counter is not legal, so a disabled watchdog keeps one idle bit.
  localparam int CNT_W = (TMO_W > 0) ? TMO_W : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // The edge that moves the counter onto all-ones is the expiry edge.
  localparam logic [CNT_W-1:0] CNT_LAST = ~CNT_W'(1);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tmo_q;

  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] pre_addr;
  logic              snoop_hit;
  logic              expire;
  logic              pre_valid;

  assign link_addr = ADDR_W'(tag_q) << GRAN_LOG2;
  assign snoop_hit = st_snoop && valid_q &&
                     gran_match(64'(st_addr), 64'(link_addr), GRAN_LOG2);
  assign expire    = (TMO_W > 0) && valid_q && (cnt_q == CNT_LAST);

  // Link state as the SC would see it through the bypass: every update of
  // this cycle except the SC's own consuming clear.
  always_comb begin
    pre_valid = valid_q;
    if (flush) begin
      pre_valid = 1'b0;
    end else if (ll_hit) begin
      pre_valid = 1'b1;
    end else if (snoop_hit || expire) begin
      pre_valid = 1'b0;
    end
  end

  assign pre_addr   = ll_hit ? ll_addr : link_addr;
  assign reg_match  = valid_q &&
                      gran_match(64'(sc_addr), 64'(link_addr), GRAN_LOG2);
  assign byp_match  = pre_valid &&
                      gran_match(64'(sc_addr), 64'(pre_addr), GRAN_LOG2);
  assign link_valid = valid_q;
  assign tmo_pulse  = tmo_q;

  // Reservation update. A retiring LL beats a same-cycle snoop so the fresh
  // link survives; the timeout only fires when nothing else touched the link.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (sc_hit) begin
        valid_q <= 1'b0;
      end else if (ll_hit) begin
        valid_q <= 1'b1;
        tag_q   <= ll_addr[ADDR_W-1:GRAN_LOG2];
        cnt_q   <= '0;
      end else if (snoop_hit) begin
        valid_q <= 1'b0;
      end else if (valid_q && (TMO_W > 0)) begin
        if (cnt_q == CNT_LAST) begin
          valid_q <= 1'b0;
          tmo_q   <= 1'b1;
        end
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/llsc_monitor.sv
// llsc_monitor
// Load-linked/store-conditional reservation monitor with one link per
// hardware context. Sits beside MEM/WB and answers SC pass/fail queries.
// Ports:
//   clk, rst        clock, async active-low reset
//   ll_we/ll_ctx/ll_addr   LL retiring: set link for ll_ctx
//   sc_req/sc_ctx/sc_addr  SC in MEM: query and consume link
//   sc_ok           SC may write (combinational)
//   st_snoop/st_addr       committed store from any master
//   flush           per-context flush vector
//   ll_bit_o        registered link-valid vector
//   tmo_evt         one-cycle pulse when any link expires
module llsc_monitor
  import llsc_pkg::*;
#(
  parameter int NUM_CTX   = 2,
  parameter int ADDR_W    = 32,
  parameter int GRAN_LOG2 = 2,
  parameter int TMO_W     = 8,
  parameter int BYPASS    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ll_we,
  input  logic [ctx_w(NUM_CTX)-1:0]  ll_ctx,
  input  logic [ADDR_W-1:0]          ll_addr,
  input  logic                       sc_req,
  input  logic [ctx_w(NUM_CTX)-1:0]  sc_ctx,
  input  logic [ADDR_W-1:0]          sc_addr,
  output logic                       sc_ok,
  input  logic                       st_snoop,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [NUM_CTX-1:0]         flush,
  output logic [NUM_CTX-1:0]         ll_bit_o,
  output logic                       tmo_evt
);

  localparam int CW = ctx_w(NUM_CTX);

  logic [NUM_CTX-1:0] ll_sel;
  logic [NUM_CTX-1:0] sc_sel;
  logic [NUM_CTX-1:0] reg_hit;
  logic [NUM_CTX-1:0] byp_hit;
  logic [NUM_CTX-1:0] tmo_vec;

  // One-hot decode of the single LL and single SC context.
  always_comb begin
    ll_sel = '0;
    sc_sel = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      ll_sel[c] = (ll_we == WriteEnable) && (ll_ctx == CW'(c));
      sc_sel[c] = sc_req && (sc_ctx == CW'(c));
    end
  end

  for (genvar g = 0; g < NUM_CTX; g++) begin : g_slot
    llsc_link_slot #(
      .ADDR_W    (ADDR_W),
      .GRAN_LOG2 (GRAN_LOG2),
      .TMO_W     (TMO_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[g]),
      .sc_hit     (sc_sel[g]),
      .ll_hit     (ll_sel[g]),
      .ll_addr    (ll_addr),
      .sc_addr    (sc_addr),
      .st_snoop   (st_snoop),
      .st_addr    (st_addr),
      .link_valid (ll_bit_o[g]),
      .reg_match  (reg_hit[g]),
      .byp_match  (byp_hit[g]),
      .tmo_pulse  (tmo_vec[g])
    );
  end

  // SC answer: the selected slot's bypassed or registered match. Forced low
  // during reset because the bypass path could otherwise see a live LL.
  always_comb begin
    sc_ok = 1'b0;
    if (rst != RstEnable) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        if (sc_sel[c]) begin
          sc_ok = (BYPASS != 0) ? byp_hit[c] : reg_hit[c];
        end
      end
    end
  end

  assign tmo_evt = |tmo_vec;

endmodule

// File: tb/tb_llsc_monitor.sv
// tb_llsc_monitor
// Directed bench for llsc_monitor. Two instances share all inputs: one with
// the SC bypass enabled and one reading registered state only. Expected
// values are queued when stimulus is driven and popped at the sample point.
module tb_llsc_monitor;
  import llsc_pkg::*;

  localparam int NUM_CTX   = 2;
  localparam int ADDR_W    = 32;
  localparam int GRAN_LOG2 = 2;
  localparam int TMO_W     = 3;

  typedef enum int {K_OK, K_OK_NB, K_BIT, K_BIT_NB, K_TMO, K_TMO_NB} kind_t;
  typedef struct {
    kind_t       kind;
    string       tag;
    logic [7:0]  exp;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ll_we;
  logic [0:0]         ll_ctx;
  logic [ADDR_W-1:0]  ll_addr;
  logic               sc_req;
  logic [0:0]         sc_ctx;
  logic [ADDR_W-1:0]  sc_addr;
  logic               st_snoop;
  logic [ADDR_W-1:0]  st_addr;
  logic [NUM_CTX-1:0] flush;

  logic               sc_ok, sc_ok_nb;
  logic [NUM_CTX-1:0] ll_bit, ll_bit_nb;
  logic               tmo_evt, tmo_evt_nb;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  llsc_monitor #(
    .NUM_CTX(NUM_CTX), .ADDR_W(ADDR_W), .GRAN_LOG2(GRAN_LOG2),
    .TMO_W(TMO_W), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .ll_we(ll_we), .ll_ctx(ll_ctx), .ll_addr(ll_addr),
    .sc_req(sc_req), .sc_ctx(sc_ctx), .sc_addr(sc_addr), .sc_ok(sc_ok),
    .st_snoop(st_snoop), .st_addr(st_addr), .flush(flush),
    .ll_bit_o(ll_bit), .tmo_evt(tmo_evt)
  );

  llsc_monitor #(
    .NUM_CTX(NUM_CTX), .ADDR_W(ADDR_W), .GRAN_LOG2(GRAN_LOG2),
    .TMO_W(TMO_W), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst(rst),
    .ll_we(ll_we), .ll_ctx(ll_ctx), .ll_addr(ll_addr),
    .sc_req(sc_req), .sc_ctx(sc_ctx), .sc_addr(sc_addr), .sc_ok(sc_ok_nb),
    .st_snoop(st_snoop), .st_addr(st_addr), .flush(flush),
    .ll_bit_o(ll_bit_nb), .tmo_evt(tmo_evt_nb)
  );

  task automatic idle();
    ll_we    = 1'b0;
    sc_req   = 1'b0;
    st_snoop = 1'b0;
    flush    = '0;
  endtask

  // Advance one full cycle; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_ll(input logic [0:0] ctx, input logic [ADDR_W-1:0] a);
    ll_we   = 1'b1;
    ll_ctx  = ctx;
    ll_addr = a;
  endtask

  task automatic apply_sc(input logic [0:0] ctx, input logic [ADDR_W-1:0] a);
    sc_req  = 1'b1;
    sc_ctx  = ctx;
    sc_addr = a;
  endtask

  task automatic apply_snoop(input logic [ADDR_W-1:0] a);
    st_snoop = 1'b1;
    st_addr  = a;
  endtask

  task automatic expect_out(input kind_t k, input string tag, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.tag  = tag;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [7:0] obs;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("[TB] FAIL scoreboard: observed empty queue, required an entry");
      return;
    end
    e = sb.pop_front();
    case (e.kind)
      K_OK:     obs = {7'd0, sc_ok};
      K_OK_NB:  obs = {7'd0, sc_ok_nb};
      K_BIT:    obs = {6'd0, ll_bit};
      K_BIT_NB: obs = {6'd0, ll_bit_nb};
      K_TMO:    obs = {7'd0, tmo_evt};
      default:  obs = {7'd0, tmo_evt_nb};
    endcase
    n_cmp++;
    assert (obs === e.exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic check_all();
    while (sb.size() > 0) check_output();
  endtask

  initial begin
    idle();
    ll_ctx  = '0;
    ll_addr = '0;
    sc_ctx  = '0;
    sc_addr = '0;
    st_addr = '0;

    // Reset held: LL and SC to the same context must not leak through bypass.
    #12;
    apply_ll(1'b0, 32'h10);
    apply_sc(1'b0, 32'h10);
    expect_out(K_OK,    "rst_sc_ok",    8'd0);
    expect_out(K_OK_NB, "rst_sc_ok_nb", 8'd0);
    expect_out(K_BIT,   "rst_ll_bit",   8'd0);
    expect_out(K_TMO,   "rst_tmo",      8'd0);
    #1 check_all();
    @(negedge clk);
    idle();
    rst = 1'b1;
    tick();
    expect_out(K_BIT, "post_rst_bit", 8'd0);
    check_all();

    // Basic pass.
    apply_ll(1'b0, 32'h1000);
    tick(); idle();
    expect_out(K_BIT,    "basic_ll_bit",    8'b01);
    expect_out(K_BIT_NB, "basic_ll_bit_nb", 8'b01);
    check_all();
    tick();
    apply_sc(1'b0, 32'h1000);
    expect_out(K_OK,    "basic_sc",    8'd1);
    expect_out(K_OK_NB, "basic_sc_nb", 8'd1);
    #1 check_all();
    tick(); idle();
    expect_out(K_BIT,    "basic_consumed",    8'b00);
    expect_out(K_BIT_NB, "basic_consumed_nb", 8'b00);
    check_all();

    // Snoop in the same granule kills the link.
    apply_ll(1'b1, 32'h2004);
    tick(); idle();
    apply_snoop(32'h2006);
    tick(); idle();
    expect_out(K_BIT, "snoop_same_bit", 8'b00);
    apply_sc(1'b1, 32'h2004);
    expect_out(K_OK,    "snoop_same_sc",    8'd0);
    expect_out(K_OK_NB, "snoop_same_sc_nb", 8'd0);
    #1 check_all();
    tick(); idle();

    // Snoop in the neighbouring granule leaves it alone.
    apply_ll(1'b1, 32'h2004);
    tick(); idle();
    apply_snoop(32'h2008);
    tick(); idle();
    expect_out(K_BIT, "snoop_next_bit", 8'b10);
    apply_sc(1'b1, 32'h2004);
    expect_out(K_OK,    "snoop_next_sc",    8'd1);
    expect_out(K_OK_NB, "snoop_next_sc_nb", 8'd1);
    #1 check_all();
    tick(); idle();
    expect_out(K_BIT, "snoop_next_consumed", 8'b00);
    check_all();

    // Flush isolation.
    apply_ll(1'b0, 32'h40);
    tick(); idle();
    apply_ll(1'b1, 32'h40);
    tick(); idle();
    flush = 2'b01;
    tick(); idle();
    expect_out(K_BIT,    "flush_bit",    8'b10);
    expect_out(K_BIT_NB, "flush_bit_nb", 8'b10);
    check_all();
    apply_sc(1'b1, 32'h40);
    expect_out(K_OK,    "flush_sc1",    8'd1);
    expect_out(K_OK_NB, "flush_sc1_nb", 8'd1);
    #1 check_all();
    tick(); idle();
    apply_sc(1'b0, 32'h40);
    expect_out(K_OK,    "flush_sc0",    8'd0);
    expect_out(K_OK_NB, "flush_sc0_nb", 8'd0);
    #1 check_all();
    tick(); idle();
    expect_out(K_BIT, "flush_end_bit", 8'b00);
    check_all();

    // Priority: LL beats snoop, flush beats LL.
    apply_ll(1'b0, 32'h80);
    apply_snoop(32'h80);
    tick(); idle();
    expect_out(K_BIT, "prio_ll_snoop", 8'b01);
    check_all();
    apply_ll(1'b0, 32'h84);
    flush = 2'b01;
    tick(); idle();
    expect_out(K_BIT, "prio_flush_ll", 8'b00);
    check_all();

    // One snoop clears links on several contexts.
    apply_ll(1'b0, 32'h500);
    tick(); idle();
    apply_ll(1'b1, 32'h500);
    tick(); idle();
    expect_out(K_BIT, "multi_set", 8'b11);
    check_all();
    apply_snoop(32'h503);
    tick(); idle();
    expect_out(K_BIT,    "multi_snoop",    8'b00);
    expect_out(K_BIT_NB, "multi_snoop_nb", 8'b00);
    check_all();

    // Same-cycle LL and SC: only the bypass instance sees the new link.
    apply_ll(1'b0, 32'h100);
    apply_sc(1'b0, 32'h100);
    expect_out(K_OK,    "byp_llsc",    8'd1);
    expect_out(K_OK_NB, "byp_llsc_nb", 8'd0);
    #1 check_all();
    tick(); idle();
    expect_out(K_BIT, "byp_sc_wins", 8'b00);
    check_all();

    // Same-cycle snoop and SC: only the bypass instance sees the kill.
    apply_ll(1'b1, 32'h300);
    tick(); idle();
    apply_sc(1'b1, 32'h300);
    apply_snoop(32'h300);
    expect_out(K_OK,    "byp_snoop_sc",    8'd0);
    expect_out(K_OK_NB, "byp_snoop_sc_nb", 8'd1);
    #1 check_all();
    tick(); idle();

    // SC to another granule fails and still consumes the link.
    apply_ll(1'b0, 32'h700);
    tick(); idle();
    apply_sc(1'b0, 32'h704);
    expect_out(K_OK,    "gran_miss_sc",    8'd0);
    expect_out(K_OK_NB, "gran_miss_sc_nb", 8'd0);
    #1 check_all();
    tick(); idle();
    expect_out(K_BIT, "gran_miss_consumed", 8'b00);
    check_all();

    // Watchdog: link dies on the 7th edge after the LL edge.
    apply_ll(1'b0, 32'h600);
    tick(); idle();
    expect_out(K_BIT, "tmo_start_bit", 8'b01);
    expect_out(K_TMO, "tmo_start_evt", 8'd0);
    check_all();
    for (int k = 1; k <= 9; k++) begin
      tick();
      expect_out(K_TMO,    $sformatf("tmo_evt_%0d", k),    (k == 7) ? 8'd1 : 8'd0);
      expect_out(K_TMO_NB, $sformatf("tmo_evt_nb_%0d", k), (k == 7) ? 8'd1 : 8'd0);
      expect_out(K_BIT,    $sformatf("tmo_bit_%0d", k),    (k < 7) ? 8'b01 : 8'b00);
      check_all();
    end

    // Asynchronous reset mid-cycle.
    apply_ll(1'b0, 32'h900);
    tick(); idle();
    apply_ll(1'b1, 32'h904);
    tick(); idle();
    expect_out(K_BIT, "arst_pre_bit", 8'b11);
    check_all();
    #2 rst = 1'b0;
    #1;
    apply_sc(1'b0, 32'h900);
    expect_out(K_BIT,    "arst_bit",      8'b00);
    expect_out(K_BIT_NB, "arst_bit_nb",   8'b00);
    expect_out(K_OK,     "arst_sc_ok",    8'd0);
    expect_out(K_OK_NB,  "arst_sc_ok_nb", 8'd0);
    #1 check_all();
    @(negedge clk);
    idle();
    rst = 1'b1;
    apply_sc(1'b0, 32'h900);
    expect_out(K_OK,    "post_arst_sc",    8'd0);
    expect_out(K_OK_NB, "post_arst_sc_nb", 8'd0);
    #1 check_all();
    tick(); idle();
    expect_out(K_BIT, "post_arst_bit", 8'b00);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
